// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the two-requester round-robin mux arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    // Width of the per-grant beat counter; never narrower than one bit.
    function automatic int cnt_width(input int max_burst);
        int w;
        w = $clog2(max_burst);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic state_t own_state(input logic idx);
        return idx ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/mux2to1_bus.sv
// Parameterised combinational 2:1 bus mux: y = sel ? b : a.
module mux2to1_bus #(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mux2to1_arbiter.sv
// Round-robin arbiter sharing one output channel between two requesters,
// holding the mux select for a burst capped at MAX_BURST beats.
module mux2to1_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] in0,
    input  logic             req1,
    input  logic [WIDTH-1:0] in1,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             sel,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy
);

    localparam int              CNT_W     = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic             last_grant, last_grant_nxt;

    logic owner, req_own, req_other, xfer, at_limit;

    assign gnt0      = (state == ST_OWN0);
    assign gnt1      = (state == ST_OWN1);
    assign busy      = (state != ST_IDLE);
    assign sel       = busy ? gnt1 : last_grant;
    assign out_valid = (gnt0 & req0) | (gnt1 & req1);

    assign owner     = gnt1;
    assign req_own   = owner ? req1 : req0;
    assign req_other = owner ? req0 : req1;
    assign xfer      = out_valid & out_ready;
    assign at_limit  = xfer && (beat_cnt == LAST_BEAT);

    mux2to1_bus #(.WIDTH(WIDTH)) u_bus (
        .sel (sel),
        .a   (in0),
        .b   (in1),
        .y   (out_data)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        state_nxt      = state;
        beat_cnt_nxt   = beat_cnt;
        last_grant_nxt = last_grant;

        unique case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester that did not own the channel last wins.
                    last_grant_nxt = (req0 && req1) ? ~last_grant : req1;
                    state_nxt      = own_state(last_grant_nxt);
                    beat_cnt_nxt   = '0;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!req_own || at_limit) begin
                    beat_cnt_nxt = '0;
                    if (req_other) begin
                        state_nxt      = own_state(~owner);
                        last_grant_nxt = ~owner;
                    end else if (!req_own) begin
                        state_nxt = ST_IDLE;
                    end
                end else if (xfer) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                beat_cnt_nxt = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            beat_cnt   <= beat_cnt_nxt;
            last_grant <= last_grant_nxt;
        end
    end

endmodule

// File: tb/tb_mux2to1_arbiter.sv
// Directed, table-driven bench for mux2to1_arbiter at MAX_BURST = 4, 2 and 1.
module tb_mux2to1_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, out_ready;
    logic [7:0] in0, in1;

    logic       v4, s4, g04, g14, b4;
    logic [7:0] d4;
    logic       v2, s2, g02, g12, b2;
    logic [7:0] d2;
    logic       v1, s1, g01, g11, b1;
    logic [7:0] d1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux2to1_arbiter #(.WIDTH(8), .MAX_BURST(4)) u_mb4 (
        .clk(clk), .rst(rst), .req0(req0), .in0(in0), .req1(req1), .in1(in1),
        .out_ready(out_ready), .out_valid(v4), .out_data(d4), .sel(s4),
        .gnt0(g04), .gnt1(g14), .busy(b4)
    );

    mux2to1_arbiter #(.WIDTH(8), .MAX_BURST(2)) u_mb2 (
        .clk(clk), .rst(rst), .req0(req0), .in0(in0), .req1(req1), .in1(in1),
        .out_ready(out_ready), .out_valid(v2), .out_data(d2), .sel(s2),
        .gnt0(g02), .gnt1(g12), .busy(b2)
    );

    mux2to1_arbiter #(.WIDTH(8), .MAX_BURST(1)) u_mb1 (
        .clk(clk), .rst(rst), .req0(req0), .in0(in0), .req1(req1), .in1(in1),
        .out_ready(out_ready), .out_valid(v1), .out_data(d1), .sel(s1),
        .gnt0(g01), .gnt1(g11), .busy(b1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // exp = {gnt0, gnt1, sel, out_valid, busy, out_data[7:0]}
    typedef struct {
        string      name;
        int         n;
        logic       rst, req0, req1, rdy;
        logic [7:0] in0, in1;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input int n,
                                input logic r, input logic q0, input logic q1, input logic rdy,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic g0, input logic g1, input logic s,
                                input logic val, input logic bz, input logic [7:0] d);
        vec_t v;
        v.name = nm; v.n = n; v.rst = r; v.req0 = q0; v.req1 = q1; v.rdy = rdy;
        v.in0 = a; v.in1 = b; v.exp = {g0, g1, s, val, bz, d};
        return v;
    endfunction

    logic [7:0] exp_mb2 [6];
    logic [7:0] exp_mb1 [6];

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0;
        in0 = 8'h10; in1 = 8'h20;

        // Reset, idle, single-requester bursts on the MAX_BURST=4 instance.
        vecs.push_back(mk("rst",      2, 1,0,0,0, 8'h10,8'h20, 0,0,1,0,0, 8'h20));
        vecs.push_back(mk("idle",    10, 0,0,0,1, 8'h10,8'h20, 0,0,1,0,0, 8'h20));
        vecs.push_back(mk("t2_req",   1, 0,1,0,1, 8'h01,8'h20, 0,0,1,0,0, 8'h20));
        for (int b = 1; b <= 6; b++)
            vecs.push_back(mk($sformatf("t2_beat%0d", b), 1, 0,1,0,1, 8'(b),8'h20, 1,0,0,1,1, 8'(b)));
        vecs.push_back(mk("t2_drop",  1, 0,0,0,1, 8'h06,8'h20, 1,0,0,0,1, 8'h06));
        vecs.push_back(mk("t2_idle",  1, 0,0,0,1, 8'h06,8'h20, 0,0,0,0,0, 8'h06));
        // Backpressure during OWN1; req0 waits, so hand-off shows the held count.
        vecs.push_back(mk("t4_req",   1, 0,0,1,1, 8'h06,8'hB1, 0,0,0,0,0, 8'h06));
        vecs.push_back(mk("t4_beat1", 1, 0,0,1,1, 8'h06,8'hB1, 0,1,1,1,1, 8'hB1));
        vecs.push_back(mk("t4_stall", 3, 0,1,1,0, 8'hA1,8'hB2, 0,1,1,1,1, 8'hB2));
        vecs.push_back(mk("t4_beat2", 1, 0,1,1,1, 8'hA1,8'hB2, 0,1,1,1,1, 8'hB2));
        vecs.push_back(mk("t4_beat3", 1, 0,1,1,1, 8'hA1,8'hB3, 0,1,1,1,1, 8'hB3));
        vecs.push_back(mk("t4_beat4", 1, 0,1,1,1, 8'hA1,8'hB4, 0,1,1,1,1, 8'hB4));
        // Early release of requester 0; OWN1 must then run a full 4-beat burst.
        vecs.push_back(mk("t5_beat1", 1, 0,1,1,1, 8'hA1,8'hB4, 1,0,0,1,1, 8'hA1));
        vecs.push_back(mk("t5_drop",  1, 0,0,1,1, 8'hA1,8'hC5, 1,0,0,0,1, 8'hA1));
        vecs.push_back(mk("t5_own1",  4, 0,1,1,1, 8'hA2,8'hC5, 0,1,1,1,1, 8'hC5));
        vecs.push_back(mk("t5_back0", 1, 0,1,1,1, 8'hA2,8'hC5, 1,0,0,1,1, 8'hA2));
        vecs.push_back(mk("t5_drop0", 1, 0,0,0,1, 8'hA2,8'hC5, 1,0,0,0,1, 8'hA2));
        vecs.push_back(mk("t5_idle",  1, 0,0,0,1, 8'hA2,8'hC5, 0,0,0,0,0, 8'hA2));

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                @(negedge clk);
                rst = vecs[i].rst; req0 = vecs[i].req0; req1 = vecs[i].req1;
                out_ready = vecs[i].rdy; in0 = vecs[i].in0; in1 = vecs[i].in1;
                #1;
                check(vecs[i].name, 32'({g04, g14, s4, v4, b4, d4}), 32'(vecs[i].exp));
            end
        end

        // Contention from reset: MAX_BURST=2 pairs, MAX_BURST=1 alternates.
        exp_mb2 = '{8'hA0, 8'hA0, 8'hB1, 8'hB1, 8'hA0, 8'hA0};
        exp_mb1 = '{8'hA0, 8'hB1, 8'hA0, 8'hB1, 8'hA0, 8'hB1};
        @(negedge clk); rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1; in0 = 8'hA0; in1 = 8'hB1;
        #1;
        check("t3_latency", 32'({v2, b2, v1, b1}), 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            check($sformatf("t3_mb2_beat%0d", i),
                  32'({g02, g12, v2, d2}), 32'({exp_mb2[i] == 8'hA0, exp_mb2[i] == 8'hB1, 1'b1, exp_mb2[i]}));
            check($sformatf("t3_mb1_beat%0d", i),
                  32'({g01, g11, v1, d1}), 32'({exp_mb1[i] == 8'hA0, exp_mb1[i] == 8'hB1, 1'b1, exp_mb1[i]}));
        end

        // Asynchronous reset in the middle of an OWN1 burst.
        @(negedge clk); req0 = 1'b0; req1 = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); req1 = 1'b1; in1 = 8'hD1; in0 = 8'hE0;
        #1;
        check("t6_idle_req", 32'({g04, g14, v4, b4}), 32'h0);
        @(negedge clk); #1;
        check("t6_own1", 32'({g14, v4, s4, d4}), 32'({1'b1, 1'b1, 1'b1, 8'hD1}));
        #1 rst = 1'b1;
        #1;
        check("t6_async_clear", 32'({g04, g14, v4, b4, s4}), 32'b00001);
        req1 = 1'b0; rst = 1'b0;
        @(negedge clk); #1;
        check("t6_idle_after", 32'({g04, g14, b4, s4}), 32'b0001);
        req0 = 1'b1; req1 = 1'b1;
        #1;
        check("t6_tie_latency", 32'({g04, g14, v4}), 32'b000);
        @(negedge clk); #1;
        check("t6_tie_winner", 32'({g04, g14, v4, d4}), 32'({1'b1, 1'b0, 1'b1, 8'hE0}));

        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux2to1_arbiter.md
Name: mux2to1_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit output channel between two requesters through a 2:1 mux.
- The block holds the mux select for the duration of a burst and performs a valid/ready handshake with the downstream consumer.
- It enforces a maximum burst length so that neither requester can starve the other.
- It sits between two producer blocks and a single consumer, and is the sequencing layer above the team's 2:1 mux primitives.

Parameters:
- WIDTH, 8, data width of in0/in1/out_data.
- MAX_BURST, 4, maximum beats transferred per grant before forced re-arbitration; legal range 1..255.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- req0  input  1  requester 0 has data; held until its final beat transfers.
- in0  input  WIDTH  requester 0 data; stable while req0=1 and not yet transferred.
- req1  input  1  requester 1 has data.
- in1  input  WIDTH  requester 1 data.
- out_ready  input  1  consumer accepts a beat this cycle.
- out_valid  output  1  beat present on out_data.
- out_data  output  WIDTH  muxed data: sel ? in1 : in0.
- sel  output  1  current mux select / owner index.
- gnt0  output  1  requester 0 owns channel; its beat transfers when gnt0&out_ready.
- gnt1  output  1  requester 1 owns channel.
- busy  output  1  state != IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, beat_cnt=0, last_grant=1, sel=1, gnt0=gnt1=0, busy=0, out_valid=0.
- State encoding: IDLE, OWN0, OWN1. gnt0=(state==OWN0), gnt1=(state==OWN1); both come directly from registered state.
- Outputs:
  - sel = 0 in OWN0, 1 in OWN1, last_grant in IDLE.
  - out_valid = (OWN0&req0)|(OWN1&req1).
  - out_data is combinational from sel.
- Transfer definition: xfer = out_valid & out_ready. beat_cnt increments on xfer, clears on any state change or re-grant.
- Latency: request in IDLE -> grant on the next clock edge, so first out_valid appears 1 cycle after req rises. No bubble on owner hand-off.
- IDLE:
  - req0&req1: grant the requester != last_grant.
  - Only one request: grant it.
  - No request: stay in IDLE.
  - On grant, last_grant <= granted index.
- OWNx, release condition: reqx=0, or (xfer and beat_cnt==MAX_BURST-1).
- OWNx, on release:
  - Other requester asserted: go to OWN(other), last_grant <= other.
  - Otherwise, if reqx is still 1 (burst-limit case): re-grant OWNx with beat_cnt=0.
  - Otherwise: go to IDLE.
- OWNx, stall: out_ready=0 keeps state and beat_cnt; out_data and sel are unchanged.
- Requester drop: reqx falling while owned is legal only after its final xfer. The arbiter releases in the cycle reqx is seen low; out_valid=0 that cycle.
- MAX_BURST=1: strict alternation per beat when both requesters are continuously active.
- Simultaneous events: a burst-limit xfer and a rising req of the other requester in the same cycle hand off at that edge.
- No-request cases: a request in IDLE coincident with nothing else needs no special case; requests seen while in IDLE with both low keep the block idle.
- beat_cnt width: CNT_W = max(1, $clog2(MAX_BURST)). beat_cnt never exceeds MAX_BURST-1; no wrap-around.
- Reset mid-burst: all state is cleared immediately (asynchronously). out_valid drops without waiting for a clock. A partially transferred burst is abandoned; requesters must re-request.

Decomposition:
- Shared package mux_arb_pkg: state typedef/localparams ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2; a helper function for CNT_W.
- One sub-module: mux2to1_bus, a parameterised WIDTH-bit combinational 2:1 mux instanced for out_data. The FSM and counter stay in the top.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles then 0, all req=0. Required: gnt0=gnt1=0, busy=0, sel=1, out_valid=0 for 10 cycles.
2. Single requester, MAX_BURST=4: req0=1 for 6 beats, out_ready=1. Required:
   - gnt0 from cycle 1.
   - Beats 1-4 transfer.
   - Re-grant to OWN0 with beat_cnt=0, beats 5-6 transfer.
   - IDLE one cycle after req0 drops.
3. Contention, MAX_BURST=2: req0 and req1 rise together from reset, both held, in0=8'hA0, in1=8'hB1. Required:
   - Requester 0 is granted first (last_grant=1).
   - Output pattern A0,A0,B1,B1,A0,A0, with no idle cycle between owners.
4. Backpressure: OWN1 at beat 1, out_ready=0 for 3 cycles. Required: gnt1, sel=1, beat_cnt, out_data=in1 all held; the burst continues when out_ready returns.
5. Early release: OWN0, req0 drops after 1 beat while req1=1. Required: OWN1 the next cycle, last_grant=1, beat_cnt=0.
6. Async reset mid-burst: rst pulses between edges during OWN1. Required: gnt1 and out_valid are 0 immediately; IDLE after release; requester 0 wins the next tie.
